// File: rtl/ovl_handshake_mc.sv
// Multi-channel req/ack handshake checker: one protocol FSM per channel,
// registered violation pulses, sticky per-channel codes and a saturating total.
module ovl_handshake_mc #(
    parameter int CHANNELS       = 4,
    parameter int MIN_ACK_CYCLE  = 1,
    parameter int MAX_ACK_CYCLE  = 8,
    parameter int REQ_DROP_CHECK = 1,
    parameter int CNT_W          = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CHANNELS-1:0]   req,
    input  logic [CHANNELS-1:0]   ack,
    output logic [CHANNELS-1:0]   fire,
    output logic [3*CHANNELS-1:0] err_code,
    output logic [CNT_W-1:0]      err_count
);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("ovl_handshake_mc: CHANNELS must be in 1..16");
    end
    if (MIN_ACK_CYCLE < 0) begin : g_bad_min
        $error("ovl_handshake_mc: MIN_ACK_CYCLE must be >= 0");
    end
    if (MAX_ACK_CYCLE < 1 || MAX_ACK_CYCLE < MIN_ACK_CYCLE) begin : g_bad_max
        $error("ovl_handshake_mc: MAX_ACK_CYCLE must be >= max(1, MIN_ACK_CYCLE)");
    end
    if (REQ_DROP_CHECK != 0 && REQ_DROP_CHECK != 1) begin : g_bad_drop
        $error("ovl_handshake_mc: REQ_DROP_CHECK must be 0 or 1");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
        $error("ovl_handshake_mc: CNT_W must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ACKED    = 2'd2
    } state_t;

    localparam logic [2:0] CODE_ACK_NO_REQ = 3'd1;
    localparam logic [2:0] CODE_TIMEOUT    = 3'd2;
    localparam logic [2:0] CODE_EARLY      = 3'd3;
    localparam logic [2:0] CODE_REQ_DROP   = 3'd4;
    localparam logic [2:0] CODE_REQ_RERISE = 3'd5;

    localparam int CW = $clog2(MAX_ACK_CYCLE + 1);
    // In WAIT_ACK the latency seen on an edge is cnt+1, so thresholds sit one below k.
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_ACK_CYCLE);
    localparam logic [CW-1:0] TIMEOUT_AT = CW'(MAX_ACK_CYCLE - 1);
    localparam logic [CW-1:0] EARLY_LIM  = CW'((MIN_ACK_CYCLE > 0) ? MIN_ACK_CYCLE - 1 : 0);

    localparam logic [32:0] CNT_MAX = (33'd1 << CNT_W) - 33'd1;

    logic [CHANNELS-1:0] fire_next;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t          state_q, state_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic            dropped_q, dropped_d;
        logic            fire_q, fire_d;
        logic [2:0]      code_q, code_d;
        logic            v_ack_no_req, v_req_drop, v_early, v_timeout, v_rerise;

        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        always_comb begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            dropped_d    = dropped_q;
            v_ack_no_req = 1'b0;
            v_req_drop   = 1'b0;
            v_early      = 1'b0;
            v_timeout    = 1'b0;
            v_rerise     = 1'b0;

            if (!enable) begin
                state_d   = IDLE;
                cnt_d     = '0;
                dropped_d = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req[c]) begin
                            cnt_d     = '0;
                            dropped_d = 1'b0;
                            if (ack[c]) begin
                                state_d = ACKED;
                                v_early = (MIN_ACK_CYCLE > 0);
                            end else begin
                                state_d = WAIT_ACK;
                            end
                        end else if (ack[c]) begin
                            v_ack_no_req = 1'b1;
                        end
                    end
                    WAIT_ACK: begin
                        if (ack[c]) begin
                            state_d   = ACKED;
                            cnt_d     = '0;
                            dropped_d = 1'b0;
                            v_early   = (cnt_q < EARLY_LIM);
                        end else if (req[c]) begin
                            // Holding at MAX_CNT is what keeps TIMEOUT to one pulse per request.
                            if (cnt_q != MAX_CNT) begin
                                cnt_d = cnt_q + CW'(1);
                            end
                            v_timeout = (cnt_q == TIMEOUT_AT);
                        end else begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            v_req_drop = (REQ_DROP_CHECK != 0);
                        end
                    end
                    ACKED: begin
                        if (!req[c]) begin
                            if (!ack[c]) begin
                                state_d   = IDLE;
                                dropped_d = 1'b0;
                            end else begin
                                dropped_d = 1'b1;
                            end
                        end else if (dropped_q && ack[c]) begin
                            v_rerise  = 1'b1;
                            dropped_d = 1'b0;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        dropped_d = 1'b0;
                    end
                endcase
            end

            fire_d = 1'b1;
            if (v_ack_no_req)    code_d = CODE_ACK_NO_REQ;
            else if (v_req_drop) code_d = CODE_REQ_DROP;
            else if (v_early)    code_d = CODE_EARLY;
            else if (v_timeout)  code_d = CODE_TIMEOUT;
            else if (v_rerise)   code_d = CODE_REQ_RERISE;
            else begin
                fire_d = 1'b0;
                code_d = code_q;
            end
        end

        // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                dropped_q <= 1'b0;
                fire_q    <= 1'b0;
                code_q    <= '0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                dropped_q <= dropped_d;
                fire_q    <= fire_d;
                code_q    <= code_d;
            end
        end

        assign fire_next[c]       = fire_d;
        assign fire[c]            = fire_q;
        assign err_code[3*c +: 3] = code_q;
    end

    logic [4:0]  n_new;
    logic [32:0] count_sum;

    always_comb begin
        n_new = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n_new = n_new + 5'(fire_next[i]);
        end
        count_sum = 33'(err_count) + 33'(n_new);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (count_sum > CNT_MAX) begin
            err_count <= CNT_MAX[CNT_W-1:0];
        end else begin
            err_count <= count_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_ovl_handshake_mc.sv
// Bench for ovl_handshake_mc: directed protocol scenarios, then randomized traffic,
// against a per-channel request-tracking model, on a wide and a 2-bit counter instance.
module tb_ovl_handshake_mc;

    localparam int CH   = 4;
    localparam int MINC = 1;
    localparam int MAXC = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  ack = '0;
    logic [3:0]  fire, fire_s;
    logic [11:0] err_code, err_code_s;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;

    ovl_handshake_mc #(
        .CHANNELS(CH), .MIN_ACK_CYCLE(MINC), .MAX_ACK_CYCLE(MAXC),
        .REQ_DROP_CHECK(1), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .ack(ack),
        .fire(fire), .err_code(err_code), .err_count(err_count)
    );

    ovl_handshake_mc #(
        .CHANNELS(CH), .MIN_ACK_CYCLE(MINC), .MAX_ACK_CYCLE(MAXC),
        .REQ_DROP_CHECK(1), .CNT_W(2)
    ) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .ack(ack),
        .fire(fire_s), .err_code(err_code_s), .err_count(err_count_s)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a request is either outstanding (with its age in edges),
    // being held after its ack, or absent.
    bit          outstanding [CH];
    int          age         [CH];
    bit          holding     [CH];
    bit          released    [CH];
    logic [3:0]  exp_fire;
    logic [11:0] exp_code;
    int          exp_cnt;
    int          exp_cnt_sat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            outstanding[c] = 1'b0;
            age[c]         = 0;
            holding[c]     = 1'b0;
            released[c]    = 1'b0;
        end
        exp_fire    = '0;
        exp_code    = '0;
        exp_cnt     = 0;
        exp_cnt_sat = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] a, input logic en);
        int         n;
        logic [2:0] code;
        n        = 0;
        exp_fire = '0;
        for (int c = 0; c < CH; c++) begin
            code = 3'd0;
            if (!en) begin
                outstanding[c] = 1'b0;
                holding[c]     = 1'b0;
                released[c]    = 1'b0;
            end else if (outstanding[c]) begin
                age[c] = age[c] + 1;
                if (a[c]) begin
                    outstanding[c] = 1'b0;
                    holding[c]     = 1'b1;
                    released[c]    = 1'b0;
                    if (age[c] < MINC) code = 3'd3;
                end else if (r[c]) begin
                    if (age[c] == MAXC) code = 3'd2;
                end else begin
                    outstanding[c] = 1'b0;
                    code = 3'd4;
                end
            end else if (holding[c]) begin
                if (!r[c] && !a[c]) begin
                    holding[c] = 1'b0;
                end else if (!r[c]) begin
                    released[c] = 1'b1;
                end else if (a[c] && released[c]) begin
                    code = 3'd5;
                    released[c] = 1'b0;
                end
            end else begin
                if (r[c] && a[c]) begin
                    holding[c]  = 1'b1;
                    released[c] = 1'b0;
                    if (MINC > 0) code = 3'd3;
                end else if (r[c]) begin
                    outstanding[c] = 1'b1;
                    age[c] = 0;
                end else if (a[c]) begin
                    code = 3'd1;
                end
            end
            if (code != 3'd0) begin
                exp_fire[c] = 1'b1;
                exp_code[3*c +: 3] = code;
                n++;
            end
        end
        exp_cnt     = (exp_cnt + n > 65535) ? 65535 : exp_cnt + n;
        exp_cnt_sat = (exp_cnt_sat + n > 3) ? 3 : exp_cnt_sat + n;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".fire"},       32'(fire),        32'(exp_fire));
        check({tag, ".err_code"},   32'(err_code),    32'(exp_code));
        check({tag, ".err_count"},  32'(err_count),   32'(exp_cnt));
        check({tag, ".fire_s"},     32'(fire_s),      32'(exp_fire));
        check({tag, ".err_code_s"}, 32'(err_code_s),  32'(exp_code));
        check({tag, ".count_s"},    32'(err_count_s), 32'(exp_cnt_sat));
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] a, input logic en, input string tag);
        req    = r;
        ack    = a;
        enable = en;
        @(posedge clock);
        if (reset) model_clear();
        else       model_edge(r, a, en);
        #1;
        compare_all(tag);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        model_clear();
        #1 compare_all(tag);
        #2 reset = 1'b0;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        model_clear();
        #2 reset = 1'b1;
        #2 compare_all("reset_async");
        @(posedge clock);
        #1 compare_all("reset_held");
        reset = 1'b0;

        // ch0 clean handshake, ack at k=2
        step(4'b0001, 4'b0000, 1'b1, "r18_rise");
        step(4'b0001, 4'b0000, 1'b1, "r18_k1");
        step(4'b0001, 4'b0001, 1'b1, "r18_ack");
        step(4'b0000, 4'b0001, 1'b1, "r18_req_low");
        step(4'b0000, 4'b0000, 1'b1, "r18_done");
        check("r18_count", 32'(err_count), 32'd0);

        // ch1 ack without request
        step(4'b0000, 4'b0010, 1'b1, "r19_ack");
        check("r19_fire", 32'(fire), 32'h2);
        check("r19_code", 32'(err_code[5:3]), 32'd1);
        check("r19_count", 32'(err_count), 32'd1);
        step(4'b0000, 4'b0000, 1'b1, "r19_after");

        // ch2 timeout, exactly one pulse at k=3
        step(4'b0100, 4'b0000, 1'b1, "r20_rise");
        step(4'b0100, 4'b0000, 1'b1, "r20_k1");
        step(4'b0100, 4'b0000, 1'b1, "r20_k2");
        step(4'b0100, 4'b0000, 1'b1, "r20_k3");
        check("r20_fire", 32'(fire), 32'h4);
        check("r20_code", 32'(err_code[8:6]), 32'd2);
        step(4'b0100, 4'b0000, 1'b1, "r20_k4");
        step(4'b0100, 4'b0000, 1'b1, "r20_k5");
        step(4'b0100, 4'b0100, 1'b1, "r20_ack");
        step(4'b0000, 4'b0100, 1'b1, "r20_req_low");
        step(4'b0000, 4'b0000, 1'b1, "r20_done");

        // ch3 early ack together with ch0 request drop
        step(4'b0001, 4'b0000, 1'b1, "r21_ch0_rise");
        step(4'b1000, 4'b1000, 1'b1, "r21_both");
        check("r21_fire", 32'(fire), 32'h9);
        check("r21_code3", 32'(err_code[11:9]), 32'd3);
        check("r21_code0", 32'(err_code[2:0]), 32'd4);
        check("r21_count", 32'(err_count), 32'd4);
        step(4'b0000, 4'b1000, 1'b1, "r21_req_low");
        step(4'b0000, 4'b0000, 1'b1, "r21_done");

        // ch3 request re-raised while ack is still high
        step(4'b1000, 4'b0000, 1'b1, "rr_rise");
        step(4'b1000, 4'b1000, 1'b1, "rr_ack");
        step(4'b0000, 4'b1000, 1'b1, "rr_drop");
        step(4'b1000, 4'b1000, 1'b1, "rr_rerise");
        check("rr_code", 32'(err_code[11:9]), 32'd5);
        step(4'b0000, 4'b0000, 1'b1, "rr_done");

        // enable low discards an outstanding request and holds codes and count
        step(4'b0100, 4'b0000, 1'b1, "en_rise");
        step(4'b0000, 4'b0000, 1'b0, "en_off");
        step(4'b0000, 4'b0010, 1'b0, "en_off_ack");
        step(4'b0000, 4'b0000, 1'b1, "en_on");

        // reset in the middle of WAIT_ACK at k=1
        step(4'b0001, 4'b0000, 1'b1, "r23_rise");
        step(4'b0001, 4'b0000, 1'b1, "r23_k1");
        #2 reset = 1'b1;
        model_clear();
        #1 compare_all("r23_in_reset");
        check("r23_count", 32'(err_count), 32'd0);
        step(4'b0001, 4'b0000, 1'b1, "r23_reset_edge");
        req = 4'b0000;
        reset = 1'b0;
        step(4'b0000, 4'b0000, 1'b1, "r23_post1");
        step(4'b0000, 4'b0000, 1'b1, "r23_post2");
        step(4'b0000, 4'b0000, 1'b1, "r23_post3");

        // 2-bit counter saturation
        async_reset_pulse("r22_reset");
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 4'b0010, 1'b1, $sformatf("r22_%0d", i));
            check($sformatf("r22_sat_%0d", i), 32'(err_count_s), 32'(sat_exp[i]));
        end
        step(4'b0000, 4'b0000, 1'b1, "r22_done");

        // randomized traffic with sticky req/ack, occasional enable drops and resets
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r, a;
            logic       en;
            r  = req ^ (4'($urandom) & 4'($urandom));
            a  = ack ^ (4'($urandom) & 4'($urandom));
            en = ($urandom_range(0, 15) != 0);
            step(r, a, en, $sformatf("rnd_%0d", i));
            if (i % 113 == 60) async_reset_pulse($sformatf("rnd_reset_%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ovl_handshake_mc.md
OVL_HANDSHAKE_MC -- requirements
Module: ovl_handshake_mc

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  CHANNELS 4 -- independent req/ack channels, legal 1..16
  MIN_ACK_CYCLE 1 -- minimum req-to-ack latency in cycles, 0 = ack allowed on the req edge
  MAX_ACK_CYCLE 8 -- maximum req-to-ack latency in cycles, legal >= max(1, MIN_ACK_CYCLE)
  REQ_DROP_CHECK 1 -- 1 = req deasserting before ack is a violation
  CNT_W 16 -- err_count width, legal 2..32
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clock input 1 -- single clock, all state updates on rising edge
  reset input 1 -- asynchronous, active-high
  enable input 1 -- checking enable
  req input CHANNELS -- per-channel request
  ack input CHANNELS -- per-channel acknowledge
  fire output CHANNELS -- per-channel one-cycle violation pulse, registered
  err_code output 3*CHANNELS -- per-channel last violation code; channel c occupies bits [3c+2:3c]
  err_count output CNT_W -- saturating total violation count
REQ-003 Illegal parameter combinations SHALL be reported by an elaboration-time $error.

Function
REQ-004 Each channel SHALL run an independent FSM with states IDLE, WAIT_ACK and ACKED, plus a latency counter cnt of width $clog2(MAX_ACK_CYCLE+1).
REQ-005 Latency k is the number of rising edges after the edge that samples req 0->1 in IDLE; k=0 means ack is sampled on that same edge.
REQ-006 IDLE transitions:
  req=1, ack=0 -> WAIT_ACK, cnt=0
  req=1, ack=1 -> ACKED; code 3 (EARLY) when MIN_ACK_CYCLE>0
  req=0, ack=1 -> stay IDLE, code 1 (ACK_NO_REQ)
REQ-007 WAIT_ACK transitions:
  ack=1 -> ACKED; code 3 when k < MIN_ACK_CYCLE
  ack=0, req=1 -> cnt+1; code 2 (TIMEOUT) on the edge where k == MAX_ACK_CYCLE
  cnt SHALL then hold, so TIMEOUT fires once per request
  req=0, ack=0 -> IDLE; code 4 (REQ_DROP) when REQ_DROP_CHECK=1
REQ-008 ACKED transitions:
  req=0, ack=0 -> IDLE
  req=0, ack=1 -> stay ACKED
  req=1 after req had dropped while ack is still high -> code 5 (REQ_BEFORE_ACK_LOW), state stays ACKED
REQ-009 A violation sampled on edge N SHALL drive fire[c]=1 for exactly the cycle after edge N and load err_code[c] with its code; err_code holds until the next violation on that channel.
REQ-010 At most one code per channel per edge; the priority SHALL be 1 > 4 > 3 > 2 > 5.
REQ-011 err_count SHALL add the popcount of the new fire bits each cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-012 With enable=0, every FSM SHALL be forced to IDLE with cnt=0, fire SHALL be 0, and err_code and err_count SHALL hold.
REQ-013 Channels SHALL NOT interact except through err_count.
REQ-014 Codes 0, 6 and 7 SHALL never be produced; code 0 means no violation since reset.

Reset
REQ-015 reset=1 SHALL immediately, without waiting for clock, force all FSMs to IDLE and set cnt, fire, err_code and err_count to 0.
REQ-016 A request in flight when reset asserts SHALL be discarded with no violation reported after reset releases.
REQ-017 The first edge after reset deasserts SHALL be evaluated normally, including a req already high, which counts as a new request.

Verification
All scenarios use CHANNELS=4, MIN_ACK_CYCLE=1, MAX_ACK_CYCLE=3, REQ_DROP_CHECK=1 unless stated.
REQ-018 ch0: req rises, ack arrives at k=2, req drops, ack drops -> fire stays 0, err_count=0.
REQ-019 ch1: ack=1 while req=0 for one cycle -> single fire[1] pulse, err_code[1]=1, err_count=1.
REQ-020 ch2: req held high, ack never arrives -> one fire[2] pulse at k=3, err_code[2]=2, no further pulses while req stays high.
REQ-021 ch3 req and ack rise on the same edge, and simultaneously ch0 req drops in WAIT_ACK -> fire=4'b1001, err_code[3]=3, err_code[0]=4, err_count increments by 2.
REQ-022 CNT_W=2 with 5 ACK_NO_REQ violations -> err_count reads 1,2,3,3,3.
REQ-023 reset asserted mid-WAIT_ACK (k=1) then released with req low -> outputs read 0 while reset is high, and no fire appears afterward.
